mesh_term_port: RTL
===================

Name: mesh_term_port

Overview:
- Terminal-side port adapter attached to one mesh router terminal.
- TX path: buffers packets from a local source in a fifo_depth FIFO and presents them to the router input through the data_out_i_in / pndng_i_in / popin handshake.
- RX path: drains the router output through the pndng / pop / data_out handshake, checks each packet's destination against its own coordinates, and keeps received and misrouted counts.

Parameters:
- pckg_sz, 40, packet width in bits (minimum 25).
- fifo_depth, 4, TX FIFO entries (power of two, at least 2).
- ROW, 0, 4-bit row coordinate of this terminal.
- COLUMN, 0, 4-bit column coordinate of this terminal.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-high reset.
- tx_push  in  1  source write strobe.
- tx_data  in  pckg_sz  source packet.
- tx_full  out  1  TX FIFO full.
- tx_overflow  out  1  sticky flag: a push was dropped.
- data_out_i_in  out  pckg_sz  TX FIFO head toward the router.
- pndng_i_in  out  1  TX FIFO not empty.
- popin  in  1  router consumes the head this cycle.
- pndng  in  1  router output has a packet.
- data_out  in  pckg_sz  router output head.
- pop  out  1  one-cycle pop strobe to the router.
- rx_stall  in  1  local sink not ready; suppresses new pops.
- rx_valid  out  1  one-cycle pulse: rx_data valid.
- rx_data  out  pckg_sz  captured packet.
- rx_err  out  1  qualifies rx_valid: destination mismatch.
- rx_count  out  16  packets received, saturating.
- err_count  out  16  misrouted packets, saturating.

Behaviour:
Reset:
- While reset is high, everything clears immediately (asynchronously): FIFO empty, pointers 0, tx_full=0, tx_overflow=0, pndng_i_in=0, data_out_i_in=0, pop=0, rx_valid=0, rx_err=0, rx_data=0, counters 0, RX FSM in IDLE.
- pndng_i_in is 0 in the first cycle after reset asserts.
- Reset mid-transfer discards all FIFO contents and any in-flight capture.

Packet fields:
- [pckg_sz-1:pckg_sz-8] next jump.
- [pckg_sz-9:pckg_sz-12] destination row.
- [pckg_sz-13:pckg_sz-16] destination column.
- [pckg_sz-17] mode.
- Remaining bits are payload.
- The TX path forwards packets unmodified.

TX FIFO:
- Circular buffer. Read and write pointers are log2(fifo_depth) bits and wrap from fifo_depth-1 to 0. Occupancy count is log2(fifo_depth)+1 bits.
- data_out_i_in is driven combinationally from the head entry; it shows 0 when empty.
- pndng_i_in = (count != 0). tx_full = (count == fifo_depth).
- Push is accepted when tx_push=1 and either not full, or full with popin=1 in the same cycle.
- A rejected push is dropped and sets tx_overflow. tx_overflow clears only on reset.
- popin while empty is ignored: no pointer move, no error.
- Simultaneous push and popin on a non-empty FIFO: count unchanged, both pointers advance.
- Push into an empty FIFO: pndng_i_in rises the next cycle, with the new packet on data_out_i_in.

RX FSM (states IDLE, POP, WAIT):
- IDLE: pop=0. Go to POP when pndng=1 and rx_stall=0.
- POP: pop=1 for exactly one cycle. rx_data is captured from data_out at the end of this cycle. Always go to WAIT.
- WAIT (one cycle):
  - rx_valid=1 and rx_err=(captured row != ROW or column != COLUMN).
  - rx_count increments unless it is 16'hFFFF.
  - err_count increments when rx_err=1, unless it is 16'hFFFF.
  - Return to IDLE.
- Pop-to-pop spacing is at least 3 cycles, which gives the router time to update pndng.
- rx_data holds its value until the next capture.
- rx_stall is sampled only in IDLE; a pop already issued completes.
- pndng dropping during POP or WAIT does not abort the capture.

Test Plan:
- Reset behaviour: assert reset asynchronously mid-cycle with 2 packets queued -> within 0 cycles, pndng_i_in=0, pop=0, tx_full=0, counters 0. After release, popin pulses do not change data_out_i_in (stays 0).
- TX fill, overflow and wrap:
  - Push 0x0100000001..0x0100000005 with no popin -> tx_full=1 after the 4th push; 5th dropped; tx_overflow=1.
  - Pop 4 -> order 01..04 on data_out_i_in; pndng_i_in=0 after the last.
  - Repeat 3 times to cross the pointer wrap -> same ordering.
- Simultaneous push and popin while full: push 0xAA00000000 together with popin -> accepted, tx_overflow stays 0, count stays 4, new head is the former 2nd entry.
- RX correct delivery:
  - Setup: ROW=2, COLUMN=3; hold pndng=1 with data_out=0x0023000055 for 2 packets.
  - Expected: pop pulses exactly 3 cycles apart; rx_valid pulses with rx_data=0x0023000055 and rx_err=0; rx_count=2; err_count=0.
- RX misroute: data_out=0x0014000077 -> rx_err=1 with rx_valid; err_count=1.
- RX stall and saturation:
  - rx_stall=1 with pndng=1 for 20 cycles -> no pop.
  - Release rx_stall -> pop on the next cycle.
  - Preload both counters to 16'hFFFF via 65535 receptions -> both hold at 16'hFFFF.

Source files
------------

// File: rtl/mesh_term_port.sv
// rtl/mesh_term_port.sv - mesh router terminal adapter: TX FIFO toward the router, RX drain with destination check
module mesh_term_port #(
  parameter int         pckg_sz    = 40,
  parameter int         fifo_depth = 4,
  parameter logic [3:0] ROW        = 4'd0,
  parameter logic [3:0] COLUMN     = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_push,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               tx_overflow,
  output logic [pckg_sz-1:0] data_out_i_in,
  output logic               pndng_i_in,
  input  logic               popin,
  input  logic               pndng,
  input  logic [pckg_sz-1:0] data_out,
  output logic               pop,
  input  logic               rx_stall,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_err,
  output logic [15:0]        rx_count,
  output logic [15:0]        err_count
);

  localparam int         AW      = $clog2(fifo_depth);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(fifo_depth);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_POP  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [AW:0]        count;
  logic               empty;
  logic               push_ok;
  logic               pop_ok;
  logic [1:0]         state;
  logic               mismatch;

  assign empty         = (count == '0);
  assign tx_full       = (count == DEPTH_C);
  assign pndng_i_in    = !empty;
  assign data_out_i_in = empty ? '0 : mem[rd_ptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = popin && !empty;
  assign push_ok = tx_push && (!tx_full || popin);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      count <= count + 1'b1;
      else if (pop_ok && !push_ok) count <= count - 1'b1;
      if (tx_push && !push_ok) tx_overflow <= 1'b1;
    end
  end

  assign mismatch = (rx_data[pckg_sz-9 -: 4] != ROW) || (rx_data[pckg_sz-13 -: 4] != COLUMN);
  assign pop      = (state == S_POP);
  assign rx_valid = (state == S_WAIT);
  assign rx_err   = (state == S_WAIT) && mismatch;

  // IDLE -> POP -> WAIT -> IDLE keeps pops at least three cycles apart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      rx_data   <= '0;
      rx_count  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (pndng && !rx_stall) state <= S_POP;
        S_POP: begin
          rx_data <= data_out;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
          if (mismatch && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
